// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write-domain pointer, full/almost-full, overflow and level for an async FIFO
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic                  woverflow,
  output logic [ADDR_WIDTH:0]   wlevel
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH:0] r_wbin;
  logic [ADDR_WIDTH:0] r_wptr;
  logic                r_wfull;
  logic                r_walmost_full;
  logic                r_woverflow;
  logic [ADDR_WIDTH:0] r_wlevel;

  logic                w_wr_en;
  logic [ADDR_WIDTH:0] w_wbin_next;
  logic [ADDR_WIDTH:0] w_wgray_next;
  logic [ADDR_WIDTH:0] w_rbin;
  logic [ADDR_WIDTH:0] w_full_cmp;
  logic [ADDR_WIDTH:0] w_level_next;

  // Each binary bit of the read pointer is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
    assign w_rbin[gi] = ^(rptr_sync >> gi);
  end

  assign w_wr_en      = winc & ~r_wfull;
  assign w_wbin_next  = r_wbin + PW'(w_wr_en);
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_level_next = w_wbin_next - w_rbin;
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign w_full_cmp   = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_woverflow    <= 1'b0;
      r_wlevel       <= '0;
    end else begin
      r_wbin         <= w_wbin_next;
      r_wptr         <= w_wgray_next;
      r_wfull        <= (w_wgray_next == w_full_cmp);
      r_walmost_full <= (w_level_next >= AF_THRESH);
      r_woverflow    <= (winc & r_wfull) | (r_woverflow & ~ovf_clr);
      r_wlevel       <= w_level_next;
    end
  end

  assign wr_en        = w_wr_en;
  assign waddr        = r_wbin[ADDR_WIDTH-1:0];
  assign wptr         = r_wptr;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign woverflow    = r_woverflow;
  assign wlevel       = r_wlevel;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - self-checking bench for wptr_full_ctrl with a count-based reference model
module tb_wptr_full_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          winc = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   rptr_sync = '0;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic          woverflow;
  logic [AW:0]   wlevel;

  int n_vec = 0;
  int n_err = 0;

  // Model: total writes accepted and total reads seen, as plain integers.
  int   m_wtot = 0;
  int   m_rtot = 0;
  logic m_full = 1'b0;
  logic m_af = 1'b0;
  logic m_ovf = 1'b0;
  int   m_level = 0;
  logic obs_wr_en;
  logic exp_wr_en;

  wptr_full_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst_n(rst_n), .winc(winc), .ovf_clr(ovf_clr), .rptr_sync(rptr_sync),
    .wr_en(wr_en), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .woverflow(woverflow), .wlevel(wlevel)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic model_clear();
    m_wtot = 0; m_rtot = 0; m_full = 0; m_af = 0; m_ovf = 0; m_level = 0;
  endtask

  // Called just after a falling edge: drive one cycle, advance the model, return at the next falling edge.
  task automatic drive(input logic w, input logic c);
    exp_wr_en = w && !m_full;
    winc = w;
    ovf_clr = c;
    rptr_sync = gray(m_rtot);
    #1;
    obs_wr_en = wr_en;
    @(posedge clk);
    m_ovf   = (w && m_full) || (m_ovf && !c);
    m_wtot  = m_wtot + (exp_wr_en ? 1 : 0);
    m_level = m_wtot - m_rtot;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= DEPTH - AFM);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    winc = 1'b0; ovf_clr = 1'b0; rptr_sync = '0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    winc = 1'b1; rptr_sync = '0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL reset_wr_en got %b exp 1", wr_en); end
    n_vec++;
    if ({waddr, wptr, wfull, walmost_full, woverflow, wlevel} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got waddr=%0d wptr=%b full=%b af=%b ovf=%b lvl=%0d exp all 0",
               waddr, wptr, wfull, walmost_full, woverflow, wlevel);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (waddr !== '0) begin n_err++; $display("FAIL reset_hold_waddr got %0d exp 0", waddr); end
    winc = 1'b0;
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= DEPTH; k++) begin
      drive(1'b1, 1'b0);
      n_vec++; if (obs_wr_en !== 1'b1) begin n_err++; $display("FAIL fill_wr_en k=%0d got %b exp 1", k, obs_wr_en); end
      n_vec++; if (waddr !== AW'(k % DEPTH)) begin n_err++; $display("FAIL fill_waddr k=%0d got %0d exp %0d", k, waddr, k % DEPTH); end
      n_vec++; if (wlevel !== (AW+1)'(k)) begin n_err++; $display("FAIL fill_level k=%0d got %0d exp %0d", k, wlevel, k); end
      n_vec++; if (wfull !== (k == DEPTH)) begin n_err++; $display("FAIL fill_full k=%0d got %b exp %b", k, wfull, k == DEPTH); end
    end
    n_vec++; if (wptr !== 4'b1100) begin n_err++; $display("FAIL fill_wptr got %b exp 1100", wptr); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0);
      n_vec++; if (obs_wr_en !== 1'b0) begin n_err++; $display("FAIL ovf_wr_en k=%0d got %b exp 0", k, obs_wr_en); end
      n_vec++; if (waddr !== 3'd0 || wptr !== 4'b1100) begin n_err++; $display("FAIL ovf_ptr k=%0d got waddr=%0d wptr=%b exp 0/1100", k, waddr, wptr); end
      n_vec++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set k=%0d got %b exp 1", k, woverflow); end
    end
    drive(1'b0, 1'b1);
    n_vec++; if (woverflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", woverflow); end
    drive(1'b1, 1'b1);
    n_vec++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_priority got %b exp 1", woverflow); end
    n_vec++; if (wlevel !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d exp 8", wlevel); end
  endtask

  task automatic test_free_one();
    m_rtot = 1;
    drive(1'b0, 1'b0);
    n_vec++; if (wfull !== 1'b0) begin n_err++; $display("FAIL free_full got %b exp 0", wfull); end
    n_vec++; if (wlevel !== 4'd7) begin n_err++; $display("FAIL free_level got %0d exp 7", wlevel); end
    drive(1'b1, 1'b0);
    n_vec++; if (obs_wr_en !== 1'b1) begin n_err++; $display("FAIL free_wr_en got %b exp 1", obs_wr_en); end
    n_vec++; if (wfull !== 1'b1) begin n_err++; $display("FAIL refull got %b exp 1", wfull); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
    n_vec++; if (wlevel !== 4'd5) begin n_err++; $display("FAIL arst_pre_level got %0d exp 5", wlevel); end
    winc = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({waddr, wptr, wfull, walmost_full, woverflow, wlevel} !== '0) begin
      n_err++;
      $display("FAIL arst_outputs got waddr=%0d wptr=%b full=%b af=%b ovf=%b lvl=%0d exp all 0",
               waddr, wptr, wfull, walmost_full, woverflow, wlevel);
    end
    winc = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if (waddr !== 3'd0) begin n_err++; $display("FAIL arst_resume0 got %0d exp 0", waddr); end
    drive(1'b1, 1'b0);
    n_vec++; if (waddr !== 3'd1) begin n_err++; $display("FAIL arst_resume1 got %0d exp 1", waddr); end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0);
    n_vec++; if (walmost_full !== 1'b0 || wlevel !== 4'd5) begin n_err++; $display("FAIL af_5 got af=%b lvl=%0d exp 0/5", walmost_full, wlevel); end
    drive(1'b1, 1'b0);
    n_vec++; if (walmost_full !== 1'b1 || wlevel !== 4'd6) begin n_err++; $display("FAIL af_6 got af=%b lvl=%0d exp 1/6", walmost_full, wlevel); end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    do_reset();
    prev = wptr;
    for (int k = 1; k <= 2 * DEPTH; k++) begin
      m_rtot = m_wtot;
      drive(1'b1, 1'b0);
      n_vec++; if ($countones(prev ^ wptr) != 1) begin n_err++; $display("FAIL wrap_onebit k=%0d got %b->%b exp one bit change", k, prev, wptr); end
      n_vec++; if (wptr !== gray(k)) begin n_err++; $display("FAIL wrap_wptr k=%0d got %b exp %b", k, wptr, gray(k)); end
      n_vec++; if (wfull !== 1'b0) begin n_err++; $display("FAIL wrap_full k=%0d got %b exp 0", k, wfull); end
      prev = wptr;
    end
    n_vec++; if (wptr !== '0) begin n_err++; $display("FAIL wrap_end got %b exp 0000", wptr); end
  endtask

  task automatic test_random();
    logic w, c;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      w = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      if (m_rtot < m_wtot && $urandom_range(0, 2) == 0) m_rtot++;
      drive(w, c);
      n_vec++; if (obs_wr_en !== exp_wr_en) begin n_err++; $display("FAIL rnd_wr_en k=%0d got %b exp %b", k, obs_wr_en, exp_wr_en); end
      n_vec++; if (waddr !== AW'(m_wtot % DEPTH)) begin n_err++; $display("FAIL rnd_waddr k=%0d got %0d exp %0d", k, waddr, m_wtot % DEPTH); end
      n_vec++; if (wptr !== gray(m_wtot)) begin n_err++; $display("FAIL rnd_wptr k=%0d got %b exp %b", k, wptr, gray(m_wtot)); end
      n_vec++; if (wlevel !== (AW+1)'(m_level)) begin n_err++; $display("FAIL rnd_level k=%0d got %0d exp %0d", k, wlevel, m_level); end
      n_vec++; if (wfull !== m_full) begin n_err++; $display("FAIL rnd_full k=%0d got %b exp %b", k, wfull, m_full); end
      n_vec++; if (walmost_full !== m_af) begin n_err++; $display("FAIL rnd_af k=%0d got %b exp %b", k, walmost_full, m_af); end
      n_vec++; if (woverflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf k=%0d got %b exp %b", k, woverflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_free_one();
    test_async_reset();
    test_almost_full();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-side pointer and status generator for the async FIFO write clock domain.
- Advances the binary write address and the Gray-coded write pointer on accepted writes.
- The Gray pointer goes to the read-domain pointer synchronizer.
- Consumes the read pointer after it has been synchronized into this domain.
- Produces the registered full, almost-full, overflow and fill-level indications used by the write client and the dual-port RAM.

Parameters:
ADDR_WIDTH, 6, RAM address bits; FIFO depth DEPTH = 2**ADDR_WIDTH; legal range ADDR_WIDTH >= 2.
AF_MARGIN, 4, almost-full asserts when level >= DEPTH - AF_MARGIN; legal range 1..DEPTH-1.

Ports:
clk  input  1  write-domain clock
rst_n  input  1  asynchronous active-low reset
winc  input  1  write request from client
ovf_clr  input  1  clears sticky overflow flag
rptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk domain
wr_en  output  1  RAM write strobe = winc & ~wfull (combinational)
waddr  output  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to synchronizer
wfull  output  1  registered full flag
walmost_full  output  1  registered almost-full flag
woverflow  output  1  sticky: a write was attempted while full
wlevel  output  ADDR_WIDTH+1  registered conservative fill level, 0..DEPTH

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state resets immediately on rst_n low.
- Reset values:
  - wbin, wptr, wlevel = 0.
  - wfull, walmost_full, woverflow = 0.
  - wr_en = winc during reset (wfull = 0), but RAM writes during reset are ignored by system convention.
- State: wbin (ADDR_WIDTH+1 bits, binary), wptr (Gray).
- Next-state: wbin_next = wbin + wr_en, modulo 2**(ADDR_WIDTH+1). wgray_next = wbin_next ^ (wbin_next >> 1). Both are registered each cycle.
- Full:
  - wfull <= (wgray_next == {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]}).
  - Full asserts in the same edge that accepts the DEPTH-th outstanding write.
- Level:
  - rbin = Gray-to-binary(rptr_sync), computed combinationally (XOR prefix from MSB).
  - wlevel <= wbin_next - rbin, modulo 2**(ADDR_WIDTH+1). Never exceeds DEPTH.
- Almost-full: walmost_full <= (wbin_next - rbin) >= DEPTH - AF_MARGIN, computed from the same difference.
- Overflow:
  - woverflow is set when winc & wfull. It holds until ovf_clr.
  - Set has priority over clear in the same cycle.
  - A blocked write changes no pointer.
- Latency:
  - An accepted write updates wptr/waddr on the next edge.
  - Reads become visible only via rptr_sync, which lags the read domain by the synchronizer depth. Flags therefore deassert late, never early; this is pessimistic and safe.
- Wrap-around:
  - wbin wraps from 2**(ADDR_WIDTH+1)-1 to 0.
  - The MSB distinguishes full from empty.
  - The Gray code changes exactly one bit per accepted write, including at the wrap.
- Simultaneous events:
  - A write and an rptr_sync change in the same cycle are both folded into the next flag and level values.
  - winc while wfull and rptr_sync frees space in the same cycle: the write is still blocked, since wr_en uses the current registered wfull.
- Reset mid-operation: pointers and flags return to 0 asynchronously. The read side must be reset together; this block does not check that.

Test Plan:
ADDR_WIDTH=3 (DEPTH=8), AF_MARGIN=2 unless stated otherwise.
1. Reset with winc=1 held, then release with rptr_sync=0 and 8 consecutive winc pulses -> waddr steps 0..7 then 0; wptr after write 8 = 4'b1100; wfull=1 on the edge accepting write 8; wlevel=8.
2. Full, winc=1 for 3 cycles -> wr_en=0, wbin unchanged, woverflow=1; pulse ovf_clr -> woverflow=0; ovf_clr and blocked winc in the same cycle -> woverflow stays 1.
3. Full, then step rptr_sync Gray 0000->0001 -> wfull=0 and wlevel=7 on the next edge; one write -> wfull=1 again.
4. Level sweep from empty: after 5 writes walmost_full=0 and wlevel=5; after the 6th write walmost_full=1 and wlevel=6.
5. Wrap: 16 writes with rptr_sync tracking each write -> wptr sequence is a Gray sequence with exactly one bit toggling per write; after 16 writes wptr=0 and wfull stays 0 throughout.
6. Assert rst_n low mid-burst with wlevel=5 -> all outputs 0 asynchronously before the next clk edge; writing resumes at waddr=0 after release.
